// File: rtl/hft_pkg.sv
// hft_pkg -- shared types and constants for the order encoder.
//   order_t : order kind carried on i_order_type (ADD / CANCEL / EXECUTE / invalid)
//   trade_t : side carried on i_trade_type (BUY / SELL)
//   stock_t : symbol carried on i_stock_symbol
//   state_t : encoder FSM states
//   Type bytes, 64-bit space-padded ASCII stock codes and message geometry.
package hft_pkg;

    typedef enum logic [1:0] {
        ORD_ADD     = 2'd0,
        ORD_CANCEL  = 2'd1,
        ORD_EXECUTE = 2'd2,
        ORD_INVALID = 2'd3
    } order_t;

    typedef enum logic {
        TRADE_BUY  = 1'b0,
        TRADE_SELL = 1'b1
    } trade_t;

    typedef enum logic [1:0] {
        STK_AAPL  = 2'd0,
        STK_AMZN  = 2'd1,
        STK_GOOGL = 2'd2,
        STK_MSFT  = 2'd3
    } stock_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [7:0] TYPE_BYTE_ADD     = 8'h41;
    localparam logic [7:0] TYPE_BYTE_CANCEL  = 8'h44;
    localparam logic [7:0] TYPE_BYTE_EXECUTE = 8'h45;

    localparam logic [63:0] CODE_AAPL  = 64'h4141504C20202020;
    localparam logic [63:0] CODE_AMZN  = 64'h414D5A4E20202020;
    localparam logic [63:0] CODE_GOOGL = 64'h474F4F474C202020;
    localparam logic [63:0] CODE_MSFT  = 64'h4D53465420202020;

    localparam int NUM_WORDS = 9;
    localparam int WORD_BITS = 32;
    localparam int MSG_BITS  = NUM_WORDS * WORD_BITS;

    // Index of the final word of a message.
    localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

    // Leading type byte for a valid order kind; invalid kinds map to 0.
    function automatic logic [7:0] type_byte(input order_t kind);
        case (kind)
            ORD_ADD:     return TYPE_BYTE_ADD;
            ORD_CANCEL:  return TYPE_BYTE_CANCEL;
            ORD_EXECUTE: return TYPE_BYTE_EXECUTE;
            default:     return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/stock_code_rom.sv
// stock_code_rom -- combinational symbol-to-code lookup.
//   i_symbol : stock symbol (AAPL / AMZN / GOOGL / MSFT)
//   o_code   : 64-bit space-padded ASCII code for that symbol
module stock_code_rom
    import hft_pkg::*;
(
    input  stock_t      i_symbol,
    output logic [63:0] o_code
);

    always_comb begin
        case (i_symbol)
            STK_AAPL:  o_code = CODE_AAPL;
            STK_AMZN:  o_code = CODE_AMZN;
            STK_GOOGL: o_code = CODE_GOOGL;
            STK_MSFT:  o_code = CODE_MSFT;
            default:   o_code = CODE_AAPL;
        endcase
    end

endmodule

// File: rtl/order_encoder.sv
// order_encoder -- packs one order into a 288-bit message and streams it
// out as nine 32-bit words, word 0 first.
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_valid / o_ready    : order handshake (o_ready only while idle)
//   i_order_type ... i_tracking_number : order fields, sampled at the handshake
//   o_word, o_word_valid, i_word_ready : output word stream
//   o_word_idx, o_last   : index of the current word, marker for word 8
//   o_err                : one-cycle pulse for an order with an invalid type
//   o_msg_count          : completed messages, wraps at 16 bits
module order_encoder
    import hft_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_order_type,
    input  logic [1:0]  i_stock_symbol,
    input  logic [31:0] i_order_id,
    input  logic [31:0] i_price,
    input  logic [31:0] i_quantity,
    input  logic        i_trade_type,
    input  logic [47:0] i_timestamp,
    input  logic [15:0] i_locate_code,
    input  logic [15:0] i_tracking_number,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    input  logic        i_word_ready,
    output logic        o_last,
    output logic [3:0]  o_word_idx,
    output logic        o_err,
    output logic [15:0] o_msg_count
);

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [15:0]         msg_count_q, msg_count_d;
    logic                err_q, err_d;
    logic [MSG_BITS-1:0] msg_q, msg_d;
    logic                load_msg;
    logic [63:0]         stock_code;
    order_t              order_kind;
    logic                send_active;

    assign order_kind = order_t'(i_order_type);

    stock_code_rom u_stock_code_rom (
        .i_symbol (stock_t'(i_stock_symbol)),
        .o_code   (stock_code)
    );

    // Message assembly from the live input fields; only captured on accept.
    always_comb begin
        msg_d          = '0;
        msg_d[7:0]     = type_byte(order_kind);
        msg_d[23:8]    = i_locate_code;
        msg_d[39:24]   = i_tracking_number;
        msg_d[87:40]   = i_timestamp;
        msg_d[151:88]  = {32'b0, i_order_id};
        case (order_kind)
            ORD_ADD: begin
                msg_d[159:152] = (trade_t'(i_trade_type) == TRADE_SELL) ? 8'h01 : 8'h00;
                msg_d[191:160] = i_quantity;
                msg_d[255:192] = stock_code;
                msg_d[287:256] = i_price;
            end
            ORD_CANCEL: begin
                msg_d[215:152] = stock_code;
            end
            ORD_EXECUTE: begin
                msg_d[183:152] = i_quantity;
                msg_d[247:184] = stock_code;
            end
            default: ;
        endcase
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        msg_count_d = msg_count_q;
        err_d       = 1'b0;
        load_msg    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    // An invalid type is still consumed, but only flags an error.
                    if (order_kind == ORD_INVALID) begin
                        err_d = 1'b1;
                    end else begin
                        load_msg = 1'b1;
                        idx_d    = 4'd0;
                        state_d  = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (i_word_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d       = 4'd0;
                        msg_count_d = msg_count_q + 16'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 4'd0;
            msg_count_q <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            msg_count_q <= msg_count_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the message register is wide data, not control; it is left
    // unreset because every read of it is gated by the SEND state.
    always_ff @(posedge i_clk) begin
        if (load_msg) begin
            msg_q <= msg_d;
        end
    end

    // Outputs are masked by i_reset so they read zero for the whole reset
    // cycle, not only after the first reset edge.
    assign send_active  = (state_q == ST_SEND) && !i_reset;
    assign o_ready      = (state_q == ST_IDLE) && !i_reset;
    assign o_word_valid = send_active;
    assign o_word       = send_active ? msg_q[{idx_q, 5'b0} +: WORD_BITS] : '0;
    assign o_word_idx   = send_active ? idx_q : 4'd0;
    assign o_last       = send_active && (idx_q == LAST_IDX);
    assign o_err        = err_q && !i_reset;
    assign o_msg_count  = i_reset ? 16'd0 : msg_count_q;

endmodule

// File: tb/tb_order_encoder.sv
// tb_order_encoder -- directed and randomized checks of order_encoder
// against a byte-offset reference model of the message layout.
module tb_order_encoder;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_order_type;
    logic [1:0]  i_stock_symbol;
    logic [31:0] i_order_id;
    logic [31:0] i_price;
    logic [31:0] i_quantity;
    logic        i_trade_type;
    logic [47:0] i_timestamp;
    logic [15:0] i_locate_code;
    logic [15:0] i_tracking_number;
    logic [31:0] o_word;
    logic        o_word_valid;
    logic        i_word_ready;
    logic        o_last;
    logic [3:0]  o_word_idx;
    logic        o_err;
    logic [15:0] o_msg_count;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_count;

    bit [63:0] stock_name [4] = '{"AAPL    ", "AMZN    ", "GOOGL   ", "MSFT    "};

    always #5 i_clk = ~i_clk;

    order_encoder dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_order_type      (i_order_type),
        .i_stock_symbol    (i_stock_symbol),
        .i_order_id        (i_order_id),
        .i_price           (i_price),
        .i_quantity        (i_quantity),
        .i_trade_type      (i_trade_type),
        .i_timestamp       (i_timestamp),
        .i_locate_code     (i_locate_code),
        .i_tracking_number (i_tracking_number),
        .o_word            (o_word),
        .o_word_valid      (o_word_valid),
        .i_word_ready      (i_word_ready),
        .o_last            (o_last),
        .o_word_idx        (o_word_idx),
        .o_err             (o_err),
        .o_msg_count       (o_msg_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference message: each field OR-ed in at its byte offset.
    function automatic logic [287:0] ref_msg(
        input logic [1:0] typ, input logic [1:0] sym,
        input logic [31:0] id, input logic [31:0] price, input logic [31:0] qty,
        input logic trade, input logic [47:0] ts,
        input logic [15:0] loc, input logic [15:0] trk);
        logic [287:0] m;
        logic [7:0]   letter;
        logic [63:0]  code;
        code = stock_name[sym];
        case (typ)
            2'd0:    letter = "A";
            2'd1:    letter = "D";
            default: letter = "E";
        endcase
        m = 288'(letter);
        m = m | (288'(loc) << 8);
        m = m | (288'(trk) << 24);
        m = m | (288'(ts) << 40);
        m = m | (288'(id) << 88);
        if (typ == 2'd0) begin
            m = m | (288'(trade) << 152);
            m = m | (288'(qty) << 160);
            m = m | (288'(code) << 192);
            m = m | (288'(price) << 256);
        end else if (typ == 2'd1) begin
            m = m | (288'(code) << 152);
        end else begin
            m = m | (288'(qty) << 152);
            m = m | (288'(code) << 184);
        end
        return m;
    endfunction

    task automatic scramble_fields();
        i_order_type      = 2'($urandom);
        i_stock_symbol    = 2'($urandom);
        i_order_id        = $urandom;
        i_price           = $urandom;
        i_quantity        = $urandom;
        i_trade_type      = 1'($urandom);
        i_timestamp       = {16'($urandom), $urandom};
        i_locate_code     = 16'($urandom);
        i_tracking_number = 16'($urandom);
    endtask

    // Presents one order at a falling edge; returns one cycle later with
    // the order fields scrambled so late capture would be visible.
    task automatic send_order(
        input logic [1:0] typ, input logic [1:0] sym,
        input logic [31:0] id, input logic [31:0] price, input logic [31:0] qty,
        input logic trade, input logic [47:0] ts,
        input logic [15:0] loc, input logic [15:0] trk);
        i_order_type      = typ;
        i_stock_symbol    = sym;
        i_order_id        = id;
        i_price           = price;
        i_quantity        = qty;
        i_trade_type      = trade;
        i_timestamp       = ts;
        i_locate_code     = loc;
        i_tracking_number = trk;
        i_valid           = 1'b1;
        check("ready_at_accept", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        scramble_fields();
    endtask

    // Consumes words 0..stop_k-1. mode 0: always ready, 1: random ready,
    // 2: ready held low for 5 cycles at word 3.
    task automatic recv_msg(input logic [287:0] m, input int mode, input int stop_k);
        int k      = 0;
        int cycles = 0;
        int stall  = 5;
        logic r;
        while (k < stop_k && cycles < 400) begin
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = 1'($urandom_range(0, 1));
            else                r = !(k == 3 && stall > 0);
            if (mode == 2 && k == 3 && !r) stall--;
            check("word_valid", 64'(o_word_valid), 64'd1);
            check($sformatf("word%0d", k), 64'(o_word), 64'(m[k*32 +: 32]));
            check("word_idx", 64'(o_word_idx), 64'(k));
            check("last", 64'(o_last), 64'(k == 8));
            check("ready_busy", 64'(o_ready), 64'd0);
            i_word_ready = r;
            @(negedge i_clk);
            cycles++;
            if (r) k++;
        end
        i_word_ready = 1'b0;
        if (k < stop_k) check("recv_timeout", 64'(k), 64'(stop_k));
        if (stop_k == 9) begin
            exp_count = exp_count + 16'd1;
            check("idle_valid", 64'(o_word_valid), 64'd0);
            check("idle_ready", 64'(o_ready), 64'd1);
            check("msg_count", 64'(o_msg_count), 64'(exp_count));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(o_ready), 64'd0);
        check({tag, "_valid"}, 64'(o_word_valid), 64'd0);
        check({tag, "_last"}, 64'(o_last), 64'd0);
        check({tag, "_err"}, 64'(o_err), 64'd0);
        check({tag, "_word"}, 64'(o_word), 64'd0);
        check({tag, "_idx"}, 64'(o_word_idx), 64'd0);
        check({tag, "_count"}, 64'(o_msg_count), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [287:0] m;
        logic [1:0]   typ;
        logic [1:0]   sym;
        logic [31:0]  id, price, qty;
        logic         trade;
        logic [47:0]  ts;
        logic [15:0]  loc, trk;

        i_reset      = 1'b1;
        i_valid      = 1'b0;
        i_word_ready = 1'b0;
        exp_count    = 16'd0;
        scramble_fields();

        // Reset state, then ready in the first cycle after reset.
        @(negedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("reset");
        i_reset = 1'b0;
        #1;
        check("ready_after_reset", 64'(o_ready), 64'd1);
        @(negedge i_clk);

        // Known ADD message with literal expected words.
        send_order(2'd0, 2'd0, 32'd7, 32'h1388, 32'd100, 1'b1, 48'd0, 16'h1234, 16'hABCD);
        m = {32'h00001388, 32'h4141504C, 32'h20202020, 32'h00000064, 32'h01000000,
             32'h00000000, 32'h07000000, 32'h000000AB, 32'hCD123441};
        recv_msg(m, 0, 9);

        // Known CANCEL message with literal expected words.
        send_order(2'd1, 2'd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 48'd0, 16'd0, 16'd0);
        m = {32'h00000000, 32'h00000000, 32'h004D5346, 32'h54202020, 32'h20000000,
             32'h00000000, 32'h05000000, 32'h00000000, 32'h00000044};
        recv_msg(m, 0, 9);

        // Backpressure stall at word 3.
        typ = 2'd2; sym = 2'd2; id = $urandom; price = $urandom; qty = $urandom;
        trade = 1'b0; ts = {16'($urandom), $urandom}; loc = 16'($urandom); trk = 16'($urandom);
        send_order(typ, sym, id, price, qty, trade, ts, loc, trk);
        recv_msg(ref_msg(typ, sym, id, price, qty, trade, ts, loc, trk), 2, 9);

        // Invalid type: one error pulse, no words, count unchanged.
        send_order(2'd3, 2'd1, $urandom, $urandom, $urandom, 1'b0, 48'd1, 16'd1, 16'd1);
        check("err_pulse", 64'(o_err), 64'd1);
        check("err_no_valid", 64'(o_word_valid), 64'd0);
        check("err_ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        check("err_cleared", 64'(o_err), 64'd0);
        check("err_no_valid2", 64'(o_word_valid), 64'd0);
        check("err_count", 64'(o_msg_count), 64'(exp_count));

        // Randomized orders with random backpressure.
        for (int n = 0; n < 30; n++) begin
            typ = 2'($urandom_range(0, 3)); sym = 2'($urandom); id = $urandom;
            price = $urandom; qty = $urandom; trade = 1'($urandom);
            ts = {16'($urandom), $urandom}; loc = 16'($urandom); trk = 16'($urandom);
            send_order(typ, sym, id, price, qty, trade, ts, loc, trk);
            if (typ == 2'd3) begin
                check("rand_err", 64'(o_err), 64'd1);
                check("rand_err_valid", 64'(o_word_valid), 64'd0);
                @(negedge i_clk);
            end else begin
                recv_msg(ref_msg(typ, sym, id, price, qty, trade, ts, loc, trk), 1, 9);
            end
        end

        // Reset in the middle of a message, at word 4.
        typ = 2'd0; sym = 2'd1; id = $urandom; price = $urandom; qty = $urandom;
        trade = 1'b1; ts = {16'($urandom), $urandom}; loc = 16'($urandom); trk = 16'($urandom);
        send_order(typ, sym, id, price, qty, trade, ts, loc, trk);
        recv_msg(ref_msg(typ, sym, id, price, qty, trade, ts, loc, trk), 0, 4);
        check("pre_reset_idx", 64'(o_word_idx), 64'd4);
        i_reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge i_clk);
        check_reset_outputs("midreset_held");
        i_reset   = 1'b0;
        exp_count = 16'd0;
        #1;
        check("ready_after_midreset", 64'(o_ready), 64'd1);
        check("valid_after_midreset", 64'(o_word_valid), 64'd0);
        @(negedge i_clk);
        check("still_idle", 64'(o_word_valid), 64'd0);

        // EXECUTE after the abandoned message starts cleanly at word 0.
        typ = 2'd2; sym = 2'd3; id = $urandom; price = $urandom; qty = $urandom;
        trade = 1'b1; ts = {16'($urandom), $urandom}; loc = 16'($urandom); trk = 16'($urandom);
        send_order(typ, sym, id, price, qty, trade, ts, loc, trk);
        check("exec_type_byte", 64'(o_word[7:0]), 64'h45);
        recv_msg(ref_msg(typ, sym, id, price, qty, trade, ts, loc, trk), 0, 9);

        // Counter wrap: preload 0xFFFF rather than streaming 65535 messages.
        force dut.msg_count_q = 16'hFFFF;
        @(negedge i_clk);
        release dut.msg_count_q;
        @(negedge i_clk);
        check("count_preload", 64'(o_msg_count), 64'hFFFF);
        exp_count = 16'hFFFF;
        typ = 2'd0; sym = 2'd2; id = $urandom; price = $urandom; qty = $urandom;
        trade = 1'b0; ts = {16'($urandom), $urandom}; loc = 16'($urandom); trk = 16'($urandom);
        send_order(typ, sym, id, price, qty, trade, ts, loc, trk);
        recv_msg(ref_msg(typ, sym, id, price, qty, trade, ts, loc, trk), 0, 9);
        check("count_wrapped", 64'(o_msg_count), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/order_encoder.md
ORDER_ENCODER -- requirements
Module: order_encoder

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-002 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port i_valid, input, 1 bit: an order is presented on the i_* order fields.
REQ-004 SHALL have port o_ready, output, 1 bit: the encoder can accept an order this cycle.
REQ-005 SHALL have port i_order_type, input, 2 bits: ADD=0, CANCEL=1, EXECUTE=2; 3 is invalid.
REQ-006 SHALL have port i_stock_symbol, input, 2 bits: AAPL=0, AMZN=1, GOOGL=2, MSFT=3.
REQ-007 SHALL have ports i_order_id, i_price and i_quantity, each input, 32 bits.
REQ-008 SHALL have port i_trade_type, input, 1 bit: BUY=0, SELL=1.
REQ-009 SHALL have ports i_timestamp (input, 48 bits), i_locate_code (input, 16 bits) and i_tracking_number (input, 16 bits).
REQ-010 SHALL have port o_word, output, 32 bits: the current message word.
REQ-011 SHALL have ports o_word_valid (output, 1 bit), i_word_ready (input, 1 bit) and o_last (output, 1 bit): o_last marks word 8.
REQ-012 SHALL have port o_word_idx, output, 4 bits: index (0 to 8) of the word on o_word.
REQ-013 SHALL have ports o_err (output, 1 bit: one-cycle pulse) and o_msg_count (output, 16 bits).

Function
REQ-014 SHALL encode each message as a 288-bit vector M, emitted as nine words, where word k = M[32k+31:32k] and word 0 is sent first.
REQ-015 Common fields SHALL be:
- M[7:0] = type byte: 0x41 ADD, 0x44 CANCEL, 0x45 EXECUTE.
- M[23:8] = locate code.
- M[39:24] = tracking number.
- M[87:40] = timestamp.
- M[151:88] = {32'b0, order_id}.
REQ-016 ADD layout SHALL be:
- M[159:152] = 0x01 for SELL, 0x00 for BUY.
- M[191:160] = quantity.
- M[255:192] = stock code.
- M[287:256] = price.
REQ-017 CANCEL layout SHALL be: M[215:152] = stock code; M[287:216] = 0.
REQ-018 EXECUTE layout SHALL be: M[183:152] = quantity; M[247:184] = stock code; M[287:248] = 0.
REQ-019 Stock codes (64-bit, ASCII space-padded) SHALL be:
- AAPL = 0x4141504C20202020.
- AMZN = 0x414D5A4E20202020.
- GOOGL = 0x474F4F474C202020.
- MSFT = 0x4D53465420202020.
REQ-020 SHALL implement an FSM with states IDLE and SEND; o_ready=1 only in IDLE.
REQ-021 On i_valid && o_ready with a valid type, SHALL register M, set idx=0 and enter SEND; word 0 SHALL be valid the next cycle.
REQ-022 In SEND, o_word_valid SHALL be 1, and o_word and o_word_idx SHALL hold stable until i_word_ready=1.
REQ-023 On an i_word_ready handshake with idx<8, SHALL increment idx; with idx==8, SHALL return to IDLE and increment o_msg_count.
REQ-024 o_msg_count SHALL wrap from 0xFFFF to 0x0000.
REQ-025 For i_order_type=3, SHALL accept the order, pulse o_err for one cycle, emit no words and stay in IDLE.
REQ-026 SHALL ignore input fields outside the accept cycle; order fields are captured only at the handshake.
REQ-027 Minimum message period SHALL be 10 cycles (9 beats plus 1 IDLE cycle).

Reset
REQ-028 While i_reset=1, SHALL force:
- the FSM to IDLE.
- o_ready=0.
- o_word_valid, o_last, o_err = 0.
- o_word and o_word_idx = 0.
- o_msg_count = 0.
REQ-029 Reset asserted mid-message SHALL abandon the message; no further words from it appear.
REQ-030 o_ready SHALL be 1 in the first cycle after i_reset deasserts.

Structure
REQ-031 SHALL place order_t, trade_t, stock_t, the type bytes, the stock codes and NUM_WORDS=9 in the shared package hft_pkg.
REQ-032 SHALL implement the symbol-to-code mapping as the combinational sub-module stock_code_rom.

Verification
REQ-033 ADD order (locate 0x1234, tracking 0xABCD, timestamp 0, id 7, SELL, qty 100, price 0x1388, AAPL) with i_word_ready=1 SHALL produce words 0xCD123441, 0x000000AB, 0x07000000, 0x00000000, 0x01000000, 0x00000064, 0x20202020, 0x4141504C, 0x00001388, with o_last set on the ninth word.
REQ-034 CANCEL order (locate 0, tracking 0, id 5, MSFT) SHALL produce word0 0x00000044, word4 0x20000000, word5 0x54202020, word6 0x004D5346, and words 7 and 8 equal to 0.
REQ-035 With i_word_ready held low for 5 cycles at word 3, o_word and o_word_idx SHALL be unchanged, the full message SHALL still take 9 handshakes, and o_ready SHALL stay low throughout.
REQ-036 An order with i_order_type=3 SHALL produce one o_err pulse, no o_word_valid, and o_msg_count unchanged.
REQ-037 i_reset asserted at word 4 SHALL drop all outputs to 0; a following EXECUTE order SHALL start cleanly at word 0 with type byte 0x45.
REQ-038 Starting from o_msg_count=0xFFFF (after 65535 messages), one more message SHALL make o_msg_count=0x0000.
